// File: rtl/clock_status_logger.sv
// ---------------------------------------------------------------------------
// clock_status_logger
//
// Purpose:
//    Watches the four per-clock "present" flags coming from the clock monitor.
//    A clock only counts as back when it has stayed present for QUAL_TICKS
//    consecutive aclk cycles. When a clock that was counted as back goes away,
//    that is a loss. Each loss sets a sticky flag and bumps a per-channel
//    saturating counter. The block raises a maskable level interrupt, and the
//    processor register bank can clear flags and counters with write-1-to-clear.
//
// Optional feature (macro CLKSTAT_TIMESTAMP_EN):
//    When the macro is defined, a free-running 32-bit timestamp counter is
//    built. Every loss captures that counter value and the lowest-numbered
//    losing channel. When the macro is not defined, last_loss_time and
//    last_loss_chan are tied to zero. The port list is the same in both builds.
//
// Parameters:
//    QUAL_TICKS  consecutive present cycles needed to qualify (2..65535)
//    CNT_WIDTH   width of each per-channel loss counter (2..16)
//
// Ports:
//    aclk            register clock
//    aresetn         synchronous active-low reset
//    ck_present[3:0] per-clock present flags, already aclk-synchronous
//    clr_strobe      one-cycle clear request
//    clr_mask[3:0]   channels to clear when clr_strobe is high
//    irq_mask[3:0]   per-channel interrupt enable
//    stable[3:0]     channel is qualified present
//    sticky_lost[3:0] loss seen since the last clear
//    loss_count      per-channel counters, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
//    all_ok          all four channels stable
//    irq             level interrupt
//    last_loss_time  timestamp of the most recent loss (optional feature)
//    last_loss_chan  channel of the most recent loss (optional feature)
// ---------------------------------------------------------------------------
module clock_status_logger #(
   parameter int QUAL_TICKS = 1024,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic [3:0]               ck_present,
   input  logic                     clr_strobe,
   input  logic [3:0]               clr_mask,
   input  logic [3:0]               irq_mask,
   output logic [3:0]               stable,
   output logic [3:0]               sticky_lost,
   output logic [4*CNT_WIDTH-1:0]   loss_count,
   output logic                     all_ok,
   output logic                     irq,
   output logic [31:0]              last_loss_time,
   output logic [1:0]               last_loss_chan
);

   typedef enum logic [1:0] {
      ABSENT  = 2'd0,
      QUALIFY = 2'd1,
      PRESENT = 2'd2
   } chanState_e;

   // The cycle that moves ABSENT to QUALIFY already counts as the first present
   // sample. Exiting QUALIFY on the zero count adds one more sample. So the load
   // value is QUAL_TICKS-2, which makes stable rise after exactly QUAL_TICKS samples.
   localparam logic [15:0]          QUAL_LOAD = 16'(QUAL_TICKS - 2);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   chanState_e           state_q     [4];
   chanState_e           state_d     [4];
   logic [15:0]          qualCount_q [4];
   logic [15:0]          qualCount_d [4];
   logic [CNT_WIDTH-1:0] lossCnt_q   [4];
   logic [CNT_WIDTH-1:0] lossCnt_d   [4];

   logic [3:0] stable_q;
   logic [3:0] stable_d;
   logic [3:0] sticky_q;
   logic [3:0] sticky_d;
   logic       allOk_q;
   logic       irq_q;
   logic [3:0] lossEvent;
   logic [3:0] clrHit;

   // State register for the four channel FSMs. Reset puts every channel back
   // in ABSENT, so clocks that are missing at start-up never look like a loss.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         for (int i = 0; i < 4; i++) begin
            state_q[i]     <= ABSENT;
            qualCount_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            state_q[i]     <= state_d[i];
            qualCount_q[i] <= qualCount_d[i];
         end
      end
   end

   // Next-state logic. Each channel runs on its own.
   // If the clock drops during qualification, the channel quietly returns to
   // ABSENT. Only a drop from PRESENT is a real loss.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         state_d[i]     = state_q[i];
         qualCount_d[i] = qualCount_q[i];
         case (state_q[i])
            ABSENT: begin
               if (ck_present[i]) begin
                  state_d[i]     = QUALIFY;
                  qualCount_d[i] = QUAL_LOAD;
               end
            end
            QUALIFY: begin
               if (!ck_present[i]) begin
                  state_d[i] = ABSENT;
               end else if (qualCount_q[i] == 16'd0) begin
                  state_d[i] = PRESENT;
               end else begin
                  qualCount_d[i] = qualCount_q[i] - 16'd1;
               end
            end
            PRESENT: begin
               if (!ck_present[i]) begin
                  state_d[i] = ABSENT;
               end
            end
            default: begin
               state_d[i] = ABSENT;
            end
         endcase
      end
   end

   // FSM output decode.
   // stable_d comes from the next state, so the stable register changes on the
   // same edge as the state register.
   // A loss event is the edge that leaves PRESENT.
   always_comb begin
      stable_d  = '0;
      lossEvent = '0;
      for (int i = 0; i < 4; i++) begin
         stable_d[i]  = (state_d[i] == PRESENT);
         lossEvent[i] = (state_q[i] == PRESENT) && !ck_present[i];
      end
   end

   // Sticky-flag and counter bookkeeping.
   // If a loss and a clear land on the same edge, the loss wins: the clear
   // wipes the old history and the new event is then recorded on top of it.
   // That way no event is ever dropped.
   always_comb begin
      clrHit   = {4{clr_strobe}} & clr_mask;
      sticky_d = sticky_q;
      for (int i = 0; i < 4; i++) begin
         lossCnt_d[i] = lossCnt_q[i];
         if (lossEvent[i]) begin
            sticky_d[i] = 1'b1;
            if (clrHit[i]) begin
               lossCnt_d[i] = CNT_ONE;
            end else if (lossCnt_q[i] != CNT_MAX) begin
               lossCnt_d[i] = lossCnt_q[i] + CNT_ONE;
            end
         end else if (clrHit[i]) begin
            sticky_d[i]  = 1'b0;
            lossCnt_d[i] = '0;
         end
      end
   end

   // Registered status outputs.
   // irq is built from the registered sticky flags and the current mask, so it
   // follows sticky_lost and irq_mask one cycle later.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         stable_q <= '0;
         allOk_q  <= 1'b0;
         sticky_q <= '0;
         irq_q    <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            lossCnt_q[i] <= '0;
         end
      end else begin
         stable_q <= stable_d;
         allOk_q  <= &stable_d;
         sticky_q <= sticky_d;
         irq_q    <= |(sticky_q & irq_mask);
         for (int i = 0; i < 4; i++) begin
            lossCnt_q[i] <= lossCnt_d[i];
         end
      end
   end

   // Pack the per-channel counters into the flat readback bus.
   always_comb begin
      loss_count = '0;
      for (int i = 0; i < 4; i++) begin
         loss_count[i*CNT_WIDTH +: CNT_WIDTH] = lossCnt_q[i];
      end
   end

   assign stable      = stable_q;
   assign all_ok      = allOk_q;
   assign sticky_lost = sticky_q;
   assign irq         = irq_q;

`ifdef CLKSTAT_TIMESTAMP_EN
   logic [31:0] tsCount_q;
   logic [31:0] lastTime_q;
   logic [1:0]  lastChan_q;
   logic [1:0]  firstLoss;

   // When several channels lose on the same edge, the lowest-numbered one is
   // the channel that gets recorded.
   always_comb begin
      firstLoss = 2'd0;
      if (lossEvent[0]) begin
         firstLoss = 2'd0;
      end else if (lossEvent[1]) begin
         firstLoss = 2'd1;
      end else if (lossEvent[2]) begin
         firstLoss = 2'd2;
      end else if (lossEvent[3]) begin
         firstLoss = 2'd3;
      end
   end

   // Free-running timestamp counter that wraps naturally.
   // The capture stores the counter value from before the loss edge.
   // clr_strobe has no effect here on purpose: the last-loss record survives
   // a clear, so software can still see what happened.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         tsCount_q  <= '0;
         lastTime_q <= '0;
         lastChan_q <= '0;
      end else begin
         tsCount_q <= tsCount_q + 32'd1;
         if (|lossEvent) begin
            lastTime_q <= tsCount_q;
            lastChan_q <= firstLoss;
         end
      end
   end

   assign last_loss_time = lastTime_q;
   assign last_loss_chan = lastChan_q;
`else
   assign last_loss_time = '0;
   assign last_loss_chan = '0;
`endif

endmodule

// File: tb/tb_clock_status_logger.sv
// ---------------------------------------------------------------------------
// tb_clock_status_logger
//
// Purpose:
//    Directed scoreboard bench for clock_status_logger with QUAL_TICKS=16 and
//    CNT_WIDTH=4. The stimulus code pushes hand-computed expectations into a
//    queue right after the edge they describe. A separate monitor pops those
//    expectations on the following falling edge and compares them against the
//    DUT outputs.
//    The last-loss expectations follow CLKSTAT_TIMESTAMP_EN, the same way the
//    design does.
// ---------------------------------------------------------------------------
module tb_clock_status_logger;

   localparam int QT = 16;
   localparam int CW = 4;

   logic            aclk = 1'b0;
   logic            aresetn;
   logic [3:0]      ckPresent;
   logic            clrStrobe;
   logic [3:0]      clrMask;
   logic [3:0]      irqMask;
   logic [3:0]      stable;
   logic [3:0]      stickyLost;
   logic [4*CW-1:0] lossCount;
   logic            allOk;
   logic            irq;
   logic [31:0]     lastLossTime;
   logic [1:0]      lastLossChan;

   typedef enum {K_STABLE, K_STICKY, K_COUNT, K_ALLOK, K_IRQ, K_LTIME, K_LCHAN} kind_e;
   typedef struct {
      string       name;
      kind_e       kind;
      logic [31:0] exp;
   } expect_t;

   expect_t     sbQueue[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] tsModel;
   expect_t     monEntry;
   logic [31:0] monActual;

`ifdef CLKSTAT_TIMESTAMP_EN
   localparam logic [31:0] EXP_TIME = 32'd1000;
   localparam logic [31:0] EXP_CHAN = 32'd1;
`else
   localparam logic [31:0] EXP_TIME = 32'd0;
   localparam logic [31:0] EXP_CHAN = 32'd0;
`endif

   clock_status_logger #(
      .QUAL_TICKS (QT),
      .CNT_WIDTH  (CW)
   ) dut (
      .aclk           (aclk),
      .aresetn        (aresetn),
      .ck_present     (ckPresent),
      .clr_strobe     (clrStrobe),
      .clr_mask       (clrMask),
      .irq_mask       (irqMask),
      .stable         (stable),
      .sticky_lost    (stickyLost),
      .loss_count     (lossCount),
      .all_ok         (allOk),
      .irq            (irq),
      .last_loss_time (lastLossTime),
      .last_loss_chan (lastLossChan)
   );

   // 10 ns clock period.
   always #5 aclk = ~aclk;

   // Independent model of the free-running timestamp: it counts the edges
   // seen since the last reset edge.
   always @(posedge aclk) begin
      if (!aresetn) tsModel <= 32'd0;
      else          tsModel <= tsModel + 32'd1;
   end

   // Monitor: on every falling edge, drain all expectations queued for the
   // edge just before it and compare them with the DUT outputs.
   always @(negedge aclk) begin
      while (sbQueue.size() > 0) begin
         monEntry = sbQueue.pop_front();
         case (monEntry.kind)
            K_STABLE: monActual = {28'd0, stable};
            K_STICKY: monActual = {28'd0, stickyLost};
            K_COUNT:  monActual = {16'd0, lossCount};
            K_ALLOK:  monActual = {31'd0, allOk};
            K_IRQ:    monActual = {31'd0, irq};
            K_LTIME:  monActual = lastLossTime;
            default:  monActual = {30'd0, lastLossChan};
         endcase
         checks++;
         if (monActual !== monEntry.exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", monEntry.name, monActual, monEntry.exp);
         end
      end
   end

   // Drive one set of inputs, then let one rising edge sample them.
   task automatic applyStimulus(input logic [3:0] ck, input logic clr,
                                input logic [3:0] cmask, input logic [3:0] imask);
      ckPresent = ck;
      clrStrobe = clr;
      clrMask   = cmask;
      irqMask   = imask;
      @(posedge aclk);
      #1;
   endtask

   // Queue the expected value of one output after the most recent edge.
   task automatic checkOutput(input string name, input kind_e kind, input logic [31:0] exp);
      expect_t e;
      e.name = name;
      e.kind = kind;
      e.exp  = exp;
      sbQueue.push_back(e);
   endtask

   initial begin
      int guard;
      aresetn   = 1'b0;
      ckPresent = 4'h0;
      clrStrobe = 1'b0;
      clrMask   = 4'h0;
      irqMask   = 4'h0;

      // Reset state.
      applyStimulus(4'h0, 1'b0, 4'h0, 4'h0);
      applyStimulus(4'h0, 1'b0, 4'h0, 4'h0);
      checkOutput("rst_stable", K_STABLE, 32'h0);
      checkOutput("rst_sticky", K_STICKY, 32'h0);
      checkOutput("rst_count",  K_COUNT,  32'h0);
      checkOutput("rst_allok",  K_ALLOK,  32'h0);
      checkOutput("rst_irq",    K_IRQ,    32'h0);
      checkOutput("rst_ltime",  K_LTIME,  32'h0);
      checkOutput("rst_lchan",  K_LCHAN,  32'h0);

      // Plan 1: all four clocks present, qualified after 16 samples.
      aresetn = 1'b1;
      for (int k = 1; k <= QT; k++) begin
         applyStimulus(4'hF, 1'b0, 4'h0, 4'h0);
         if (k == QT - 1) begin
            checkOutput("p1_stable_15", K_STABLE, 32'h0);
            checkOutput("p1_allok_15",  K_ALLOK,  32'h0);
         end
      end
      checkOutput("p1_stable_16", K_STABLE, 32'hF);
      checkOutput("p1_allok_16",  K_ALLOK,  32'h1);
      checkOutput("p1_sticky",    K_STICKY, 32'h0);
      checkOutput("p1_count",     K_COUNT,  32'h0);
      checkOutput("p1_irq",       K_IRQ,    32'h0);

      // Plan 2: an aborted qualification is not a loss.
      aresetn = 1'b0;
      applyStimulus(4'h0, 1'b0, 4'h0, 4'h0);
      applyStimulus(4'h0, 1'b0, 4'h0, 4'h0);
      aresetn = 1'b1;
      repeat (10) applyStimulus(4'b0010, 1'b0, 4'h0, 4'h0);
      applyStimulus(4'b0000, 1'b0, 4'h0, 4'h0);
      checkOutput("p2_abort_sticky", K_STICKY, 32'h0);
      checkOutput("p2_abort_count",  K_COUNT,  32'h0);
      for (int k = 1; k <= QT; k++) begin
         applyStimulus(4'b0010, 1'b0, 4'h0, 4'h0);
         if (k == QT - 1) checkOutput("p2_stable_15", K_STABLE, 32'h0);
      end
      checkOutput("p2_stable_16", K_STABLE, 32'h2);
      checkOutput("p2_sticky",    K_STICKY, 32'h0);
      checkOutput("p2_count",     K_COUNT,  32'h0);
      repeat (QT) applyStimulus(4'hF, 1'b0, 4'h0, 4'h0);
      checkOutput("p2_all_stable", K_STABLE, 32'hF);
      checkOutput("p2_allok",      K_ALLOK,  32'h1);

      // Plan 3: loss on ck2 with only ck2 unmasked, then a clear.
      applyStimulus(4'b1011, 1'b0, 4'h0, 4'b0100);
      checkOutput("p3_stable",  K_STABLE, 32'hB);
      checkOutput("p3_allok",   K_ALLOK,  32'h0);
      checkOutput("p3_sticky",  K_STICKY, 32'h4);
      checkOutput("p3_count",   K_COUNT,  32'h0100);
      checkOutput("p3_irq_lag", K_IRQ,    32'h0);
      applyStimulus(4'hF, 1'b0, 4'h0, 4'b0100);
      checkOutput("p3_irq_set", K_IRQ,    32'h1);
      applyStimulus(4'hF, 1'b1, 4'b0100, 4'b0100);
      checkOutput("p3_clr_sticky", K_STICKY, 32'h0);
      checkOutput("p3_clr_count",  K_COUNT,  32'h0);
      checkOutput("p3_clr_irqlag", K_IRQ,    32'h1);
      applyStimulus(4'hF, 1'b0, 4'h0, 4'b0100);
      checkOutput("p3_irq_clr", K_IRQ, 32'h0);
      repeat (QT - 3) applyStimulus(4'hF, 1'b0, 4'h0, 4'b0100);
      checkOutput("p3_requal", K_STABLE, 32'hF);

      // Plan 4: 20 losses on ck0; the counter must saturate at 15.
      for (int n = 1; n <= 20; n++) begin
         applyStimulus(4'b1110, 1'b0, 4'h0, 4'b0100);
         checkOutput($sformatf("p4_count_%0d", n), K_COUNT, (n > 15) ? 32'd15 : 32'(n));
         repeat (QT) applyStimulus(4'hF, 1'b0, 4'h0, 4'b0100);
      end
      checkOutput("p4_sticky",     K_STICKY, 32'h1);
      checkOutput("p4_irq_masked", K_IRQ,    32'h0);
      applyStimulus(4'hF, 1'b0, 4'h0, 4'b0001);
      checkOutput("p4_irq_unmask", K_IRQ,    32'h1);

      // Plan 5: a ck3 loss on the same edge as a ck3 clear.
      for (int n = 1; n <= 5; n++) begin
         applyStimulus(4'b0111, 1'b0, 4'h0, 4'b0001);
         repeat (QT) applyStimulus(4'hF, 1'b0, 4'h0, 4'b0001);
      end
      checkOutput("p5_count_pre", K_COUNT, 32'h500F);
      applyStimulus(4'b0111, 1'b1, 4'b1000, 4'b0001);
      checkOutput("p5_sticky", K_STICKY, 32'h9);
      checkOutput("p5_count",  K_COUNT,  32'h100F);
      repeat (QT) applyStimulus(4'hF, 1'b0, 4'h0, 4'b0001);
      checkOutput("p5_requal", K_STABLE, 32'hF);

      // Plan 6: simultaneous ck1/ck3 loss at timestamp 1000, record survives a clear.
      guard = 0;
      while (tsModel != 32'd1000 && guard < 5000) begin
         applyStimulus(4'hF, 1'b0, 4'h0, 4'b0001);
         guard++;
      end
      if (guard >= 5000) begin
         checks++;
         errors++;
         $display("[TB] FAIL p6_ts_wait: actual=timeout required=timestamp 1000");
      end
      applyStimulus(4'b0101, 1'b0, 4'h0, 4'b0001);
      checkOutput("p6_sticky", K_STICKY, 32'hB);
      checkOutput("p6_count",  K_COUNT,  32'h201F);
      checkOutput("p6_ltime",  K_LTIME,  EXP_TIME);
      checkOutput("p6_lchan",  K_LCHAN,  EXP_CHAN);
      applyStimulus(4'hF, 1'b1, 4'hF, 4'b0001);
      checkOutput("p6_clr_sticky", K_STICKY, 32'h0);
      checkOutput("p6_clr_count",  K_COUNT,  32'h0);
      checkOutput("p6_hold_ltime", K_LTIME,  EXP_TIME);
      checkOutput("p6_hold_lchan", K_LCHAN,  EXP_CHAN);
      repeat (3) applyStimulus(4'hF, 1'b0, 4'h0, 4'b0001);
      checkOutput("p6_hold2_ltime", K_LTIME, EXP_TIME);

      @(negedge aclk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Safety net so the run can never hang.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: actual=timeout required=completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/clock_status_logger.md
Name: clock_status_logger

Overview:
- Consumes the 4-bit per-clock "present" vector from the clock monitor, in the aclk domain.
- Qualifies each clock's return with a stability window.
- Records loss events as sticky flags and saturating per-clock counters.
- Raises a maskable interrupt and presents all of this to the processor register bank for readback and write-1-to-clear.

Parameters:
- QUAL_TICKS, 1024: consecutive aclk cycles a clock must read present before it is declared stable (range 2..65535).
- CNT_WIDTH, 8: width of each per-clock loss counter (range 2..16).

Ports:
- aclk, input, 1: register clock (125 MHz XDMA clock).
- aresetn, input, 1: reset, synchronous, active-low, clock aclk.
- ck_present, input, 4: per-clock present flags from the clock monitor, already aclk-synchronous.
- clr_strobe, input, 1: one-cycle clear request from the register bank.
- clr_mask, input, 4: channels to clear; sampled when clr_strobe=1.
- irq_mask, input, 4: per-channel interrupt enable; 1 = enabled.
- stable, output, 4: channel is in the PRESENT state.
- sticky_lost, output, 4: a loss event has occurred since the last clear.
- loss_count, output, 4*CNT_WIDTH: channel i counter at bits [i*CNT_WIDTH +: CNT_WIDTH].
- all_ok, output, 1: all four channels stable.
- irq, output, 1: interrupt, level, active-high.
- last_loss_time, output, 32: timestamp of the most recent loss (optional feature).
- last_loss_chan, output, 2: channel of the most recent loss (optional feature).

Behaviour:
- Reset (aresetn=0 at an aclk edge):
  - every channel FSM goes to ABSENT;
  - qualification counters go to 0;
  - stable, sticky_lost, loss_count, all_ok, irq, last_loss_time and last_loss_chan go to 0;
  - the timestamp counter goes to 0.
  - Reset mid-qualification or mid-clear discards all state; no event is recorded.
- All outputs are registered.
- Per-channel FSM, four independent copies:
  - ABSENT: if ck_present[i]=1, go to QUALIFY and load qcount = QUAL_TICKS-2; otherwise stay.
  - QUALIFY:
    - if ck_present[i]=0, go to ABSENT; this is not a loss event;
    - else if qcount=0, go to PRESENT;
    - else decrement qcount.
  - PRESENT: if ck_present[i]=0, go to ABSENT and generate a loss event for channel i.
  - Net timing: stable[i] is visible high in the cycle after the edge that sampled ck_present[i]=1 for the QUAL_TICKS-th consecutive time.
  - Start-up absence after reset never counts as a loss.
- stable[i] = (state==PRESENT). all_ok = &stable, updated on the same edge as stable.
- Loss event on channel i, taking effect on the edge that leaves PRESENT:
  - sticky_lost[i] <= 1;
  - loss_count[i] increments, saturating at 2^CNT_WIDTH-1 with no wrap.
- Clear: on an edge with clr_strobe=1, each channel with clr_mask[i]=1 has sticky_lost[i] <= 0 and loss_count[i] <= 0.
- Clear and loss event on the same edge for the same channel: the event wins.
  - sticky_lost[i]=1 and loss_count[i]=1 afterwards.
  - No event is ever dropped.
- irq is registered: irq <= |(sticky_lost & irq_mask), using current register values, so it lags sticky_lost by one cycle.
  - Changing irq_mask affects irq one cycle later.
- Multiple channels losing on the same edge: each channel is handled independently; the optional timestamp capture uses the lowest-numbered channel.

Optional Feature:
- Macro: CLKSTAT_TIMESTAMP_EN.
- Defined:
  - a free-running 32-bit timestamp counter increments every aclk cycle from 0 after reset and wraps from 0xFFFFFFFF to 0;
  - on any loss event, last_loss_time <= the counter value at that edge, and last_loss_chan <= the lowest-numbered losing channel;
  - both hold until the next loss event or reset and are not affected by clr_strobe.
- Not defined:
  - no counter is instantiated;
  - last_loss_time and last_loss_chan are constant 0.
- Port list is identical in both builds.

Test Plan:
Bench parameters are QUAL_TICKS=16 and CNT_WIDTH=4 unless stated otherwise.
1. Reset, then ck_present=4'b1111 held -> stable=0 for 15 cycles, stable=4'b1111 and all_ok=1 visible after the 16th sampling edge; sticky_lost=0, loss_count=0, irq=0.
2. Qualification abort: ck_present[1] high for 10 cycles, low for 1 cycle, then high -> no loss recorded (sticky_lost[1]=0, count 0); stable[1] rises 16 cycles after the re-rise.
3. Loss with irq_mask=4'b0100: with all channels stable, drop ck_present[2] for 1 cycle -> next cycle stable[2]=0, all_ok=0, sticky_lost=4'b0100, loss_count[2]=1; the cycle after, irq=1.
   - Then pulse clr_strobe with clr_mask=4'b0100 -> sticky_lost=0 and count 0 next cycle, and irq=0 the cycle after.
4. Saturation: 20 loss/requalify cycles on ck0 -> loss_count[0]=15 after the 15th loss and stays 15.
5. Clear colliding with a ck3 loss on the same edge (clr_mask=4'b1000, loss_count[3]=5 beforehand) -> sticky_lost[3]=1, loss_count[3]=1.
6. With CLKSTAT_TIMESTAMP_EN defined: simultaneous loss of ck1 and ck3 at timestamp 1000 -> last_loss_chan=1, last_loss_time=1000, both held through a later clr_strobe.
   - Without the macro: both outputs remain 0 throughout.
